// File: rtl/cache_if_pkg.sv
// Shared encodings for the cache refill/writeback interface: request types,
// last-beat marker and responder FSM states (reused by the AXI bridge).
package cache_if_pkg;

    localparam logic [2:0] RT_BYTE = 3'b000;
    localparam logic [2:0] RT_HALF = 3'b001;
    localparam logic [2:0] RT_WORD = 3'b010;
    localparam logic [2:0] RT_LINE = 3'b100;

    localparam logic [1:0] RET_LAST = 2'b01;

    localparam int NUM_BANKS = 4;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_BEAT = 2'd2,
        R_GAP  = 2'd3
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache <-> memory refill/writeback bus; master is the cache, slave the responder.
interface cache_mem_responder_if;

    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic [1:0]   ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );

    modport slave (
        input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );

endinterface

// File: rtl/mem_bank.sv
// One word-interleaved bank of the responder array: async read, byte-enable sync write.
module mem_bank #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side model for the cache refill/writeback bus with tunable read latency,
// beat spacing and write busy time; data lives in four word-interleaved banks.
module cache_mem_responder
    import cache_if_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int RD_LAT   = 4,
    parameter int WR_LAT   = 2,
    parameter int BEAT_GAP = 0
) (
    input  logic clk,
    input  logic resetn,
    cache_mem_responder_if.slave bus
);

    localparam int IDX_W = MEM_AW - 2;
    localparam int CNT_W = $clog2(max3(RD_LAT, WR_LAT, BEAT_GAP + 1) + 1);

    rd_state_t                  rstate, rstate_nx;
    wr_state_t                  wstate, wstate_nx;
    logic [CNT_W-1:0]           rcnt, rcnt_nx, wcnt, wcnt_nx;
    logic [1:0]                 beat_cnt, beat_cnt_nx, last_beat;
    logic [MEM_AW-1:0]          rd_base, rd_base_nx, rd_word;
    logic                       rd_line, rd_line_nx;
    logic                       live, rd_acc, wr_acc, wr_line;
    logic [NUM_BANKS-1:0][3:0]  bank_we;
    logic [NUM_BANKS-1:0][31:0] bank_wdata, bank_rdata;
    logic                       unused_addr_bits;

    assign unused_addr_bits = ^{bus.rd_addr[31:MEM_AW+2], bus.rd_addr[1:0],
                                bus.wr_addr[31:MEM_AW+2], bus.wr_addr[1:0]};

    // rdy stays low through the reset cycle and rises on the first edge after release
    assign bus.rd_rdy = live & (rstate == R_IDLE);
    assign bus.wr_rdy = live & (wstate == W_IDLE);
    assign rd_acc     = bus.rd_req & bus.rd_rdy & resetn;
    assign wr_acc     = bus.wr_req & bus.wr_rdy & resetn;

    assign last_beat     = rd_line ? 2'd3 : 2'd0;
    assign rd_word       = rd_base + MEM_AW'(beat_cnt);
    assign bus.ret_valid = (rstate == R_BEAT);
    assign bus.ret_last  = (bus.ret_valid && beat_cnt == last_beat) ? RET_LAST : 2'b00;
    assign bus.ret_data  = bus.ret_valid ? bank_rdata[rd_word[1:0]] : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rstate   <= R_IDLE;
            wstate   <= W_IDLE;
            rcnt     <= '0;
            wcnt     <= '0;
            beat_cnt <= '0;
            rd_base  <= '0;
            rd_line  <= 1'b0;
            live     <= 1'b0;
        end else begin
            rstate   <= rstate_nx;
            wstate   <= wstate_nx;
            rcnt     <= rcnt_nx;
            wcnt     <= wcnt_nx;
            beat_cnt <= beat_cnt_nx;
            rd_base  <= rd_base_nx;
            rd_line  <= rd_line_nx;
            live     <= 1'b1;
        end
    end

    always_comb begin
        rstate_nx   = rstate;
        rcnt_nx     = rcnt;
        beat_cnt_nx = beat_cnt;
        rd_base_nx  = rd_base;
        rd_line_nx  = rd_line;
        unique case (rstate)
            R_IDLE: if (rd_acc) begin
                rd_line_nx  = (bus.rd_type == RT_LINE);
                rd_base_nx  = rd_line_nx ? {bus.rd_addr[MEM_AW+1:4], 2'b00}
                                         : bus.rd_addr[MEM_AW+1:2];
                rcnt_nx     = CNT_W'(RD_LAT - 1);
                beat_cnt_nx = 2'd0;
                rstate_nx   = R_WAIT;
            end
            R_WAIT, R_GAP: begin
                if (rcnt == '0) rstate_nx = R_BEAT;
                else            rcnt_nx   = rcnt - 1'b1;
            end
            R_BEAT: begin
                if (beat_cnt == last_beat) begin
                    beat_cnt_nx = 2'd0;
                    rstate_nx   = R_IDLE;
                end else begin
                    beat_cnt_nx = beat_cnt + 2'd1;
                    if (BEAT_GAP > 0) begin
                        rcnt_nx   = CNT_W'(BEAT_GAP - 1);
                        rstate_nx = R_GAP;
                    end
                end
            end
            default: rstate_nx = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_nx = wstate;
        wcnt_nx   = wcnt;
        unique case (wstate)
            W_IDLE: if (wr_acc) begin
                wcnt_nx   = CNT_W'(WR_LAT - 1);
                wstate_nx = W_BUSY;
            end
            W_BUSY: begin
                if (wcnt == '0) wstate_nx = W_IDLE;
                else            wcnt_nx   = wcnt - 1'b1;
            end
            default: wstate_nx = W_IDLE;
        endcase
    end

    // Line writes hit all four banks at once; anything else is a masked single-word write
    assign wr_line = (bus.wr_type == RT_LINE);

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_wdata[b] = wr_line ? bus.wr_data[32*b +: 32] : bus.wr_data[31:0];
            bank_we[b]    = 4'h0;
            if (wr_acc)
                bank_we[b] = wr_line ? 4'hF
                           : ((bus.wr_addr[3:2] == 2'(b)) ? bus.wr_wstrb : 4'h0);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(.IDX_W(IDX_W)) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .widx  (bus.wr_addr[MEM_AW+1:4]),
            .wdata (bank_wdata[b]),
            .ridx  (rd_word[MEM_AW-1:2]),
            .rdata (bank_rdata[b])
        );
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench: two responders (BEAT_GAP 0 and 2) share clock, reset and write
// traffic; sel routes read requests and observation to one of them.
module tb_cache_mem_responder;
    import cache_if_pkg::*;

    localparam int RD_LAT = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         sel;
    logic         rd_req, wr_req;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         o_rd_rdy, o_wr_rdy, o_ret_valid;
    logic [1:0]   o_ret_last;
    logic [31:0]  o_ret_data;
    int           n_chk = 0;
    int           n_fail = 0;

    cache_mem_responder_if b0 ();
    cache_mem_responder_if b1 ();

    assign b0.rd_req = rd_req & ~sel;
    assign b1.rd_req = rd_req & sel;
    assign b0.rd_type = rd_type;   assign b1.rd_type = rd_type;
    assign b0.rd_addr = rd_addr;   assign b1.rd_addr = rd_addr;
    assign b0.wr_req = wr_req;     assign b1.wr_req = wr_req;
    assign b0.wr_type = wr_type;   assign b1.wr_type = wr_type;
    assign b0.wr_addr = wr_addr;   assign b1.wr_addr = wr_addr;
    assign b0.wr_wstrb = wr_wstrb; assign b1.wr_wstrb = wr_wstrb;
    assign b0.wr_data = wr_data;   assign b1.wr_data = wr_data;

    assign o_rd_rdy    = sel ? b1.rd_rdy    : b0.rd_rdy;
    assign o_wr_rdy    = sel ? b1.wr_rdy    : b0.wr_rdy;
    assign o_ret_valid = sel ? b1.ret_valid : b0.ret_valid;
    assign o_ret_last  = sel ? b1.ret_last  : b0.ret_last;
    assign o_ret_data  = sel ? b1.ret_data  : b0.ret_data;

    cache_mem_responder #(.MEM_AW(12), .RD_LAT(RD_LAT), .WR_LAT(2), .BEAT_GAP(0)) dut (
        .clk(clk), .resetn(resetn), .bus(b0));
    cache_mem_responder #(.MEM_AW(12), .RD_LAT(RD_LAT), .WR_LAT(2), .BEAT_GAP(2)) dut_g (
        .clk(clk), .resetn(resetn), .bus(b1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                      input logic [3:0] strb, input logic [127:0] data);
        int n;
        wr_req = 1'b1; wr_type = typ; wr_addr = addr; wr_wstrb = strb; wr_data = data;
        n = 0;
        while (!o_wr_rdy && n < 64) begin tick(); n++; end
        chk({tag, ".wacc"}, 32'(o_wr_rdy), 32'd1);
        tick();
        wr_req = 1'b0;
    endtask

    // Checks every cycle from accept to one past the last beat against the timing formula
    task automatic rd_burst(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                            input logic [127:0] line, input int gap, input bit hold);
        int nb, last_c, n, i;
        bit vld_e;
        nb = (typ == RT_LINE) ? 4 : 1;
        last_c = RD_LAT + (nb - 1) * (gap + 1);
        rd_req = 1'b1; rd_type = typ; rd_addr = addr;
        n = 0;
        while (!o_rd_rdy && n < 64) begin tick(); n++; end
        chk({tag, ".racc"}, 32'(o_rd_rdy), 32'd1);
        tick();
        if (!hold) rd_req = 1'b0;
        for (int c = 1; c <= last_c + 1; c++) begin
            tick();
            vld_e = (c >= RD_LAT) && (c <= last_c) && (((c - RD_LAT) % (gap + 1)) == 0);
            chk($sformatf("%s.vld@%0d", tag, c), 32'(o_ret_valid), 32'(vld_e));
            chk($sformatf("%s.rdy@%0d", tag, c), 32'(o_rd_rdy), 32'(c == last_c + 1));
            if (vld_e) begin
                i = (c - RD_LAT) / (gap + 1);
                chk($sformatf("%s.data%0d", tag, i), o_ret_data, line[32*i +: 32]);
                chk($sformatf("%s.last%0d", tag, i), 32'(o_ret_last),
                    (i == nb - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; sel = 1'b0;
        rd_req = 1'b0; rd_type = 3'b0; rd_addr = 32'h0;
        wr_req = 1'b0; wr_type = 3'b0; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = '0;
        tick(); tick();
        chk("rst.rd_rdy", 32'(o_rd_rdy), 32'd0);
        chk("rst.wr_rdy", 32'(o_wr_rdy), 32'd0);
        chk("rst.ret_valid", 32'(o_ret_valid), 32'd0);
        chk("rst.ret_last", 32'(o_ret_last), 32'd0);
        chk("rst.ret_data", o_ret_data, 32'd0);
        resetn = 1'b1;
        tick();
        chk("rel.rd_rdy", 32'(o_rd_rdy), 32'd1);
        chk("rel.wr_rdy", 32'(o_wr_rdy), 32'd1);
        sel = 1'b1;
        chk("rel.g.rd_rdy", 32'(o_rd_rdy), 32'd1);
        sel = 1'b0;

        // 1: line write then line read, beats at +4..+7
        wr("t1", 32'h1C000040, RT_LINE, 4'h0, 128'h44444444_33333333_22222222_11111111);
        rd_burst("t1", 32'h1C000040, RT_LINE, 128'h44444444_33333333_22222222_11111111, 0, 1'b0);

        // 2: masked word write over AABBCCDD, write busy for exactly 2 cycles
        wr("t2a", 32'h1C000048, RT_WORD, 4'hF, {96'h0, 32'hAABBCCDD});
        wr("t2b", 32'h1C000048, RT_WORD, 4'b0101, {96'h0, 32'h11223344});
        chk("t2.wbusy0", 32'(o_wr_rdy), 32'd0);
        tick();
        chk("t2.wbusy1", 32'(o_wr_rdy), 32'd0);
        tick();
        chk("t2.wfree", 32'(o_wr_rdy), 32'd1);
        rd_burst("t2", 32'h1C000048, RT_WORD, {96'h0, 32'hAA22CC44}, 0, 1'b0);

        // 3: line write, line read of the same line accepted the next cycle
        wr("t3", 32'h1C000080, RT_LINE, 4'h0, 128'h88888888_77777777_66666666_55555555);
        fork
            rd_burst("t3", 32'h1C000080, RT_LINE, 128'h88888888_77777777_66666666_55555555,
                     0, 1'b0);
            begin
                chk("t3.wbusy0", 32'(o_wr_rdy), 32'd0);
                tick();
                chk("t3.wbusy1", 32'(o_wr_rdy), 32'd0);
                tick();
                chk("t3.wfree", 32'(o_wr_rdy), 32'd1);
            end
        join

        // 4: rd_req held through a burst; second request taken after the last beat
        rd_burst("t4a", 32'h1C000040, RT_LINE, 128'h44444444_AA22CC44_22222222_11111111, 0, 1'b1);
        rd_burst("t4b", 32'h1C000084, RT_WORD, {96'h0, 32'h66666666}, 0, 1'b0);

        // byte type returns the whole word; upper address bits alias; unknown type acts as word
        rd_burst("byte", 32'h1C00004B, RT_BYTE, {96'h0, 32'hAA22CC44}, 0, 1'b0);
        rd_burst("alias", 32'h9C00004C, 3'b011, {96'h0, 32'h44444444}, 0, 1'b0);

        // 5: BEAT_GAP=2 responder, beats at +4,+7,+10,+13
        sel = 1'b1;
        rd_burst("t5", 32'h2C000040, RT_LINE, 128'h44444444_AA22CC44_22222222_11111111, 2, 1'b0);
        sel = 1'b0;

        // 6: reset right after the first beat drops the rest of the burst
        rd_req = 1'b1; rd_type = RT_LINE; rd_addr = 32'h1C000080;
        chk("t6.racc", 32'(o_rd_rdy), 32'd1);
        tick();
        rd_req = 1'b0;
        repeat (RD_LAT) tick();
        chk("t6.beat0", 32'(o_ret_valid), 32'd1);
        chk("t6.data0", o_ret_data, 32'h55555555);
        resetn = 1'b0;
        tick();
        chk("t6.rst.vld", 32'(o_ret_valid), 32'd0);
        chk("t6.rst.rdy", 32'(o_rd_rdy), 32'd0);
        chk("t6.rst.data", o_ret_data, 32'd0);
        resetn = 1'b1;
        tick();
        chk("t6.rel.rdy", 32'(o_rd_rdy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t6.quiet%0d", k), 32'(o_ret_valid), 32'd0);
            tick();
        end
        rd_burst("t6r", 32'h1C000080, RT_LINE, 128'h88888888_77777777_66666666_55555555, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
